// File: rtl/axi_lite_master.sv
// AXI4-Lite initiator: turns one local command at a time into an AW/W/B or AR/R
// transaction and returns completion status and read data on the response port.
module axi_lite_master #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                ACLK,
  input  logic                ARESETN,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_wstrb,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic                rsp_write,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic [1:0]          rsp_resp,
  output logic                AWVALID,
  input  logic                AWREADY,
  output logic [ADDR_W-1:0]   AWADDR,
  output logic [2:0]          AWPROT,
  output logic                WVALID,
  input  logic                WREADY,
  output logic [DATA_W-1:0]   WDATA,
  output logic [DATA_W/8-1:0] WSTRB,
  input  logic                BVALID,
  output logic                BREADY,
  input  logic [1:0]          BRESP,
  output logic                ARVALID,
  input  logic                ARREADY,
  output logic [ADDR_W-1:0]   ARADDR,
  output logic [2:0]          ARPROT,
  input  logic                RVALID,
  output logic                RREADY,
  input  logic [DATA_W-1:0]   RDATA,
  input  logic [1:0]          RRESP
);

  // state     | meaning
  // S_IDLE    | waiting for a command, cmd_ready high
  // S_WR_REQ  | AW and W offered independently until both handshake
  // S_WR_RESP | BREADY high, waiting for the write response
  // S_RD_REQ  | ARVALID high until the address handshake
  // S_RD_RESP | RREADY high, waiting for read data
  // S_RSP     | completion presented on rsp_*, held until rsp_ready
  typedef enum logic [2:0] {
    S_IDLE, S_WR_REQ, S_WR_RESP, S_RD_REQ, S_RD_RESP, S_RSP
  } state_t;

  state_t              r_state;
  logic                r_awvalid, r_wvalid, r_bready, r_arvalid, r_rready, r_rsp_valid;
  logic                r_aw_done, r_w_done;
  logic [ADDR_W-1:0]   r_awaddr, r_araddr;
  logic [DATA_W-1:0]   r_wdata, r_rsp_rdata;
  logic [DATA_W/8-1:0] r_wstrb;
  logic [1:0]          r_rsp_resp;
  logic                r_rsp_write;

  logic w_aw_hs, w_w_hs, w_aw_fin, w_w_fin;

  assign w_aw_hs  = r_awvalid & AWREADY;
  assign w_w_hs   = r_wvalid & WREADY;
  assign w_aw_fin = r_aw_done | w_aw_hs;
  assign w_w_fin  = r_w_done | w_w_hs;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_state     <= S_IDLE;
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_bready    <= 1'b0;
      r_arvalid   <= 1'b0;
      r_rready    <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_aw_done   <= 1'b0;
      r_w_done    <= 1'b0;
      r_awaddr    <= '0;
      r_araddr    <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_rsp_rdata <= '0;
      r_rsp_resp  <= 2'b00;
      r_rsp_write <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            if (cmd_write) begin
              r_awaddr  <= cmd_addr;
              r_wdata   <= cmd_wdata;
              r_wstrb   <= cmd_wstrb;
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_state   <= S_WR_REQ;
            end else begin
              r_araddr  <= cmd_addr;
              r_arvalid <= 1'b1;
              r_state   <= S_RD_REQ;
            end
          end
        end
        S_WR_REQ: begin
          if (w_aw_hs) r_awvalid <= 1'b0;
          if (w_w_hs)  r_wvalid  <= 1'b0;
          // Done flags remember which channel already finished when they complete apart.
          if (w_aw_fin && w_w_fin) begin
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_bready  <= 1'b1;
            r_state   <= S_WR_RESP;
          end else begin
            r_aw_done <= w_aw_fin;
            r_w_done  <= w_w_fin;
          end
        end
        S_WR_RESP: begin
          if (BVALID) begin
            r_bready    <= 1'b0;
            r_rsp_resp  <= BRESP;
            r_rsp_write <= 1'b1;
            r_rsp_rdata <= '0;
            r_rsp_valid <= 1'b1;
            r_state     <= S_RSP;
          end
        end
        S_RD_REQ: begin
          if (ARREADY) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= S_RD_RESP;
          end
        end
        S_RD_RESP: begin
          if (RVALID) begin
            r_rready    <= 1'b0;
            r_rsp_rdata <= RDATA;
            r_rsp_resp  <= RRESP;
            r_rsp_write <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_state     <= S_RSP;
          end
        end
        S_RSP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready = (r_state == S_IDLE);
  assign rsp_valid = r_rsp_valid;
  assign rsp_write = r_rsp_write;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_resp  = r_rsp_resp;
  assign AWVALID   = r_awvalid;
  assign AWADDR    = r_awaddr;
  assign AWPROT    = 3'b000;
  assign WVALID    = r_wvalid;
  assign WDATA     = r_wdata;
  assign WSTRB     = r_wstrb;
  assign BREADY    = r_bready;
  assign ARVALID   = r_arvalid;
  assign ARADDR    = r_araddr;
  assign ARPROT    = 3'b000;
  assign RREADY    = r_rready;

endmodule

// File: tb/tb_axi_lite_master.sv
// Scoreboard bench for axi_lite_master: directed commands against a slave model
// with per-channel wait cycles; a negedge monitor pops and checks each response.
module tb_axi_lite_master;
  logic        ACLK = 1'b0;
  logic        ARESETN = 1'b0;
  logic        cmd_valid = 1'b0, cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0, cmd_wdata = '0;
  logic [3:0]  cmd_wstrb = '0;
  logic        cmd_ready, rsp_valid, rsp_write;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic        ARVALID, ARREADY, RVALID, RREADY;
  logic [31:0] AWADDR, WDATA, ARADDR, RDATA;
  logic [3:0]  WSTRB;
  logic [2:0]  AWPROT, ARPROT;
  logic [1:0]  BRESP, RRESP;

  always #5 ACLK = ~ACLK;

  axi_lite_master #(.ADDR_W(32), .DATA_W(32)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWPROT(AWPROT),
    .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB),
    .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR), .ARPROT(ARPROT),
    .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP)
  );

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [1:0]  resp;
    logic [31:0] rdata;
    int          lat;
    int          aw_c;
    int          w_c;
    int          ar_c;
    int          hold;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // slave model: READY/VALID after a programmable number of wait cycles
  int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  int aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;
  logic [1:0]  bresp_c = 2'b00, rresp_c = 2'b00;
  logic [31:0] rdata_c = '0;
  logic [31:0] cap_awaddr = '0, cap_wdata = '0, cap_araddr = '0;
  logic [3:0]  cap_wstrb = '0;

  assign AWREADY = AWVALID ? (aw_cnt >= aw_dly) : (aw_dly == 0);
  assign WREADY  = WVALID  ? (w_cnt  >= w_dly)  : (w_dly  == 0);
  assign BVALID  = BREADY  ? (b_cnt  >= b_dly)  : (b_dly  == 0);
  assign ARREADY = ARVALID ? (ar_cnt >= ar_dly) : (ar_dly == 0);
  assign RVALID  = RREADY  ? (r_cnt  >= r_dly)  : (r_dly  == 0);
  assign BRESP = bresp_c;
  assign RRESP = rresp_c;
  assign RDATA = rdata_c;

  always @(posedge ACLK) begin
    aw_cnt <= (AWVALID && !AWREADY) ? aw_cnt + 1 : 0;
    w_cnt  <= (WVALID  && !WREADY)  ? w_cnt + 1  : 0;
    b_cnt  <= (BREADY  && !BVALID)  ? b_cnt + 1  : 0;
    ar_cnt <= (ARVALID && !ARREADY) ? ar_cnt + 1 : 0;
    r_cnt  <= (RREADY  && !RVALID)  ? r_cnt + 1  : 0;
    if (AWVALID && AWREADY) cap_awaddr <= AWADDR;
    if (WVALID && WREADY) begin
      cap_wdata <= WDATA;
      cap_wstrb <= WSTRB;
    end
    if (ARVALID && ARREADY) cap_araddr <= ARADDR;
  end

  int cyc = 0;
  always @(posedge ACLK) cyc <= cyc + 1;

  // monitor + response consumer
  initial begin
    int t0, first_rsp, aw_c, w_c, ar_c, rsp_c, unstable, early;
    logic        p_awv, p_wv, p_arv, p_rv;
    logic [31:0] p_awaddr, p_wdata, p_araddr;
    logic [3:0]  p_wstrb;
    logic [34:0] p_rsp;
    exp_t e;
    t0 = 0; first_rsp = 0; aw_c = 0; w_c = 0; ar_c = 0; rsp_c = 0; unstable = 0; early = 0;
    p_awv = 0; p_wv = 0; p_arv = 0; p_rv = 0;
    p_awaddr = '0; p_wdata = '0; p_araddr = '0; p_wstrb = '0; p_rsp = '0;
    rsp_ready = 1'b0;
    forever begin
      @(negedge ACLK);
      if (AWVALID) aw_c++;
      if (WVALID) w_c++;
      if (ARVALID) ar_c++;
      if (AWVALID && p_awv && AWADDR !== p_awaddr) unstable++;
      if (WVALID && p_wv && {WDATA, WSTRB} !== {p_wdata, p_wstrb}) unstable++;
      if (ARVALID && p_arv && ARADDR !== p_araddr) unstable++;
      if (BREADY && (AWVALID || WVALID)) early++;
      rsp_ready = 1'b0;
      if (rsp_valid) begin
        if (!p_rv) begin
          first_rsp = cyc;
          rsp_c = 0;
        end else if ({rsp_write, rsp_rdata, rsp_resp} !== p_rsp) unstable++;
        if (cmd_ready) unstable++;
        rsp_c++;
        if (exp_q.size() == 0) begin
          check("unexpected_rsp", 1, 0);
          rsp_ready = 1'b1;
        end else if (rsp_c > exp_q[0].hold) begin
          rsp_ready = 1'b1;
          e = exp_q.pop_front();
          check("rsp_write", rsp_write, e.wr);
          check("rsp_rdata", rsp_rdata, e.rdata);
          check("rsp_resp", rsp_resp, e.resp);
          check("latency", first_rsp - t0, e.lat);
          check("stability", unstable, 0);
          if (e.wr) begin
            check("aw_cycles", aw_c, e.aw_c);
            check("w_cycles", w_c, e.w_c);
            check("awaddr", cap_awaddr, e.addr);
            check("wdata", cap_wdata, e.wdata);
            check("wstrb", cap_wstrb, e.strb);
            check("bready_early", early, 0);
          end else begin
            check("ar_cycles", ar_c, e.ar_c);
            check("araddr", cap_araddr, e.addr);
          end
        end
      end
      if (cmd_valid && cmd_ready && ARESETN) begin
        check("accept_no_rsp", rsp_valid, 0);
        t0 = cyc + 1;
        aw_c = 0; w_c = 0; ar_c = 0; unstable = 0; early = 0;
      end
      p_awv = AWVALID; p_wv = WVALID; p_arv = ARVALID; p_rv = rsp_valid;
      p_awaddr = AWADDR; p_wdata = WDATA; p_wstrb = WSTRB; p_araddr = ARADDR;
      p_rsp = {rsp_write, rsp_rdata, rsp_resp};
    end
  end

  task automatic run(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] strb, input logic [1:0] resp, input logic [31:0] rdata,
                     input int lat, input int awc, input int wc, input int arc, input int hold,
                     input int awd, input int wd, input int bd, input int ard, input int rd,
                     input bit push);
    exp_t e;
    int n;
    n = 0;
    @(negedge ACLK);
    while (!(cmd_ready || rsp_valid) && n < 100) begin
      @(negedge ACLK);
      n++;
    end
    if (n >= 100) check("issue_wait_timeout", 1, 0);
    @(posedge ACLK);
    #1;
    aw_dly = awd; w_dly = wd; b_dly = bd; ar_dly = ard; r_dly = rd;
    if (wr) bresp_c = resp;
    else begin
      rresp_c = resp;
      rdata_c = rdata;
    end
    cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata; cmd_wstrb = strb;
    cmd_valid = 1'b1;
    e.wr = wr; e.addr = addr; e.wdata = wdata; e.strb = strb; e.resp = resp;
    e.rdata = wr ? 32'h0 : rdata; e.lat = lat; e.aw_c = awc; e.w_c = wc; e.ar_c = arc;
    e.hold = hold;
    if (push) exp_q.push_back(e);
    n = 0;
    @(negedge ACLK);
    while (!cmd_ready && n < 100) begin
      @(negedge ACLK);
      n++;
    end
    if (n >= 100) check("accept_timeout", 1, 0);
    @(posedge ACLK);
    #1;
    cmd_valid = 1'b0;
  endtask

  initial begin
    int n;
    repeat (2) @(negedge ACLK);
    check("reset_cmd_ready", cmd_ready, 1);
    check("reset_valids", {AWVALID, WVALID, BREADY, ARVALID, RREADY, rsp_valid}, 6'b0);
    check("reset_addr", {AWADDR, ARADDR}, 64'h0);
    check("reset_wdata", {WDATA, WSTRB}, 36'h0);
    check("reset_rsp", {rsp_rdata, rsp_resp, rsp_write}, 35'h0);
    check("prot", {AWPROT, ARPROT}, 6'b0);
    @(posedge ACLK);
    #1 ARESETN = 1'b1;

    //   wr addr          wdata          strb resp rdata         lat aw w ar hold awd wd bd ard rd
    run(1, 32'h0000_0004, 32'hDEAD_BEEF, 4'hF, 2'b00, 32'h0,         2, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1);
    run(1, 32'h0000_0010, 32'hA5A5_0001, 4'h3, 2'b00, 32'h0,         5, 4, 1, 0, 0, 3, 0, 0, 0, 0, 1);
    run(1, 32'h0000_0014, 32'h0BAD_F00D, 4'hC, 2'b00, 32'h0,         5, 1, 4, 0, 0, 0, 3, 0, 0, 0, 1);
    run(0, 32'h0000_0008, 32'h0,         4'h0, 2'b00, 32'h1234_5678, 6, 0, 0, 3, 0, 0, 0, 0, 2, 2, 1);
    run(1, 32'h0000_0020, 32'h1111_2222, 4'hF, 2'b10, 32'h0,         3, 1, 1, 0, 0, 0, 0, 1, 0, 0, 1);
    run(0, 32'h0000_0024, 32'h0,         4'h0, 2'b11, 32'hCAFE_F00D, 2, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1);
    run(1, 32'h0000_0030, 32'h55AA_55AA, 4'hF, 2'b00, 32'h0,         2, 1, 1, 0, 5, 0, 0, 0, 0, 0, 1);
    run(0, 32'h0000_0034, 32'h0,         4'h0, 2'b01, 32'h0F0F_0F0F, 2, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1);

    // write abandoned by reset while AW is still waiting
    run(1, 32'h0000_0038, 32'h7777_8888, 4'hF, 2'b00, 32'h0,         0, 0, 0, 0, 0, 10, 0, 0, 0, 0, 0);
    repeat (2) @(negedge ACLK);
    check("awvalid_pending", AWVALID, 1);
    @(posedge ACLK);
    #1 ARESETN = 1'b0;
    @(negedge ACLK);
    check("midreset_valids", {AWVALID, WVALID, BREADY, ARVALID, RREADY, rsp_valid}, 6'b0);
    check("midreset_cmd_ready", cmd_ready, 1);
    @(posedge ACLK);
    #1 ARESETN = 1'b1;
    run(1, 32'h0000_0040, 32'h89AB_CDEF, 4'h5, 2'b00, 32'h0,         2, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1);

    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge ACLK);
      n++;
    end
    check("drain", exp_q.size(), 0);
    repeat (3) @(negedge ACLK);
    check("final_idle", {cmd_ready, rsp_valid}, 2'b10);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_lite_master.md
# axi_lite_master

AXI4-Lite initiator that turns single-word commands from a local command port into AW/W/B or AR/R channel transactions, one at a time. It sits between on-chip control logic (sequencer, test driver) and the AXI-Lite slave memory block, and returns the completion status and read data on a local response port.

## Interface
- ADDR_W, 32, address width of cmd_addr, AWADDR and ARADDR
- DATA_W, 32, data width; strobe width is DATA_W/8; only 32 is supported
- ACLK  in  1  clock; all logic on the rising edge
- ARESETN  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_W  byte address
- cmd_wdata  in  DATA_W  write data
- cmd_wstrb  in  DATA_W/8  byte-lane enables
- rsp_valid  out  1  completion available; held until rsp_ready
- rsp_ready  in  1  completion consumed
- rsp_write  out  1  completed command was a write
- rsp_rdata  out  DATA_W  read data; 0 for writes
- rsp_resp  out  2  captured BRESP or RRESP
- AWVALID / AWREADY / AWADDR / AWPROT  out / in / out ADDR_W / out 3  write address; AWPROT constant 3'b000
- WVALID / WREADY / WDATA / WSTRB  out / in / out DATA_W / out DATA_W/8  write data
- BVALID / BREADY / BRESP  in / out / in 2  write response
- ARVALID / ARREADY / ARADDR / ARPROT  out / in / out ADDR_W / out 3  read address; ARPROT constant 3'b000
- RVALID / RREADY / RDATA / RRESP  in / out / in DATA_W / in 2  read data

## Operation
- Single outstanding transaction; states IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP.
- IDLE: cmd_ready=1. On cmd_valid&&cmd_ready capture addr/wdata/wstrb/write; go WR_REQ (write) or RD_REQ (read).
- WR_REQ: AWVALID and WVALID both asserted the cycle after acceptance. Each channel independent: on its handshake edge the VALID drops next cycle and an aw_done / w_done flag sets. AWADDR/WDATA/WSTRB stable while VALID is high. AW and W may complete on the same edge or in either order. When both done -> WR_RESP, flags cleared.
- WR_RESP: BREADY=1. On BVALID&&BREADY capture BRESP, rsp_write=1, rsp_rdata=0, BREADY drops -> RSP.
- RD_REQ: ARVALID=1 until ARVALID&&ARREADY -> RD_RESP.
- RD_RESP: RREADY=1. On RVALID&&RREADY capture RDATA and RRESP, rsp_write=0, RREADY drops -> RSP.
- RSP: rsp_valid=1, rsp_* stable. On rsp_ready -> IDLE.
- VALIDs never deassert before handshake; no VALID waits on a READY (AXI rule).
- BRESP/RRESP non-OKAY values passed through unchanged; no retry.
- BVALID or RVALID arriving in any other state is ignored (READY is low).
- No timeout; a non-responding slave holds the FSM in its current state until reset.

## Timing
- Reset (async assert, sync release): state IDLE; cmd_ready=1; AWVALID, WVALID, BREADY, ARVALID, RREADY, rsp_valid = 0; AWADDR, WDATA, WSTRB, ARADDR, rsp_rdata, rsp_resp, rsp_write = 0.
- Reset mid-transaction: all VALID/READY outputs drop immediately, transaction discarded, no response produced.
- Acceptance edge = T0. Write with zero-wait slave (AWREADY, WREADY, BVALID already high): AW/W valid in cycle T0..T1, handshakes at T1, BREADY in cycle T1..T2, B handshake at T2, rsp_valid from T2. Minimum 2 cycles from acceptance to rsp_valid.
- Read with zero-wait slave: AR handshake at T1, R handshake at T2, rsp_valid from T2.
- Each slave wait cycle on any channel adds exactly one cycle.
- rsp_ready high at the first RSP cycle: rsp_valid lasts 1 cycle; cmd_ready returns the next cycle. Back-to-back command throughput is 1 per 4 cycles minimum.
- All outputs are registered or decoded from the state register only. No combinational path from input to output.

## Test plan
- Write 0x0000_0004, data 0xDEAD_BEEF, strb 0xF, zero-wait slave BRESP=00 -> AWADDR=4, WDATA=0xDEADBEEF, WSTRB=F, each VALID high exactly 1 cycle; rsp_valid at T2 with rsp_write=1, rsp_resp=00.
- Write with AWREADY delayed 3 cycles, WREADY immediate -> WVALID drops after 1 cycle, AWVALID held 4 cycles with stable AWADDR, BREADY only after AW done; same with W delayed instead.
- Read 0x0000_0008, slave RDATA=0x1234_5678 with ARREADY and RVALID each delayed 2 cycles, RRESP=00 -> rsp_rdata=0x12345678, rsp_write=0, ARVALID stable until handshake.
- Write with BRESP=10, then read with RRESP=11 -> rsp_resp=10 then 11; the FSM returns to IDLE both times.
- rsp_ready held low 5 cycles -> rsp_valid and rsp_* stable for 5 cycles, cmd_ready=0 throughout, a second cmd_valid is not accepted until after the rsp handshake.
- ARESETN pulsed low while AWVALID is high awaiting AWREADY -> all VALID/READY outputs 0 during reset, no rsp_valid, cmd_ready=1; a new write after release completes normally.
